// File: rtl/dmux8_pkg.sv
// Shared definitions for the 8-way dispatcher: channel geometry, state enum
// and the channel one-hot encoder.
package dmux8_pkg;

   localparam int unsigned CH_COUNT = 8;
   localparam int unsigned CH_W     = 3;

   typedef enum logic {
      ST_EMPTY,
      ST_FULL
   } state_e;

   // One-hot encode of a 3-bit channel index.
   function automatic logic [CH_COUNT-1:0] ch_onehot(input logic [CH_W-1:0] ch);
      ch_onehot     = '0;
      ch_onehot[ch] = 1'b1;
   endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational first-set-bit pick over an 8-bit request, scanning upward
// from ptr with wrap. idx falls back to ptr when no request bit is set.
module rr_pick8
   import dmux8_pkg::*;
(
   input  logic [CH_COUNT-1:0] req,
   input  logic [CH_W-1:0]     ptr,
   output logic [CH_W-1:0]     idx,
   output logic                found
);

   logic [CH_W-1:0] cand;

   // Scan from the farthest offset down so the nearest ready channel wins.
   always_comb begin
      found = 1'b0;
      idx   = ptr;
      cand  = ptr;
      for (int i = CH_COUNT - 1; i >= 0; i--) begin
         cand = ptr + CH_W'(i);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/dmux8_dispatcher.sv
// One-entry valid/ready front end for the 8-way demultiplexer. A held beat is
// steered to one channel, chosen by round-robin or by an explicit destination.
// Optional build macro DMUX8_SKIP_BUSY_EN: round-robin skips channels whose
// out_ready is low at the accept edge.
module dmux8_dispatcher
   import dmux8_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_data,
   input  logic                in_fixed,
   input  logic [CH_W-1:0]     in_dest,
   output logic [CH_COUNT-1:0] out_valid,
   input  logic [CH_COUNT-1:0] out_ready,
   output logic [WIDTH-1:0]    out_data,
   output logic [CH_W-1:0]     sel,
   output logic [CH_W-1:0]     rr_ptr
);

   state_e           state_q;
   logic [WIDTH-1:0] data_q;
   logic [CH_W-1:0]  sel_q;
   logic [CH_W-1:0]  rr_q;
   logic             fixed_q;

   logic             deliver;
   logic             accept;
   logic [CH_W-1:0]  eff_ptr;
   logic [CH_W-1:0]  rr_choice;
   logic [CH_W-1:0]  new_sel;

   assign deliver  = (state_q == ST_FULL) && out_ready[sel_q];
   assign in_ready = (state_q == ST_EMPTY) || deliver;
   assign accept   = in_valid && in_ready;

   // A round-robin beat leaving this edge advances the pointer; a new beat
   // accepted in the same edge must already see the advanced value.
   assign eff_ptr = (deliver && !fixed_q) ? sel_q + CH_W'(1) : rr_q;

`ifdef DMUX8_SKIP_BUSY_EN
   logic [CH_W-1:0] pick_idx;
   logic            pick_found;

   rr_pick8 u_pick (
      .req   (out_ready),
      .ptr   (eff_ptr),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign rr_choice = pick_found ? pick_idx : eff_ptr;
`else
   assign rr_choice = eff_ptr;
`endif

   assign new_sel = in_fixed ? in_dest : rr_choice;

   // Holding register FSM: accept has priority over returning to EMPTY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         sel_q   <= '0;
         rr_q    <= '0;
         fixed_q <= 1'b0;
      end else begin
         if (deliver && !fixed_q) begin
            rr_q <= sel_q + CH_W'(1);
         end
         if (accept) begin
            state_q <= ST_FULL;
            data_q  <= in_data;
            sel_q   <= new_sel;
            fixed_q <= in_fixed;
         end else if (deliver) begin
            state_q <= ST_EMPTY;
            sel_q   <= '0;
            fixed_q <= 1'b0;
         end
      end
   end

   // Outputs come straight from the holding registers.
   always_comb begin
      out_valid = (state_q == ST_FULL) ? ch_onehot(sel_q) : '0;
      out_data  = data_q;
      sel       = sel_q;
      rr_ptr    = rr_q;
   end

endmodule

// File: tb/tb_dmux8_dispatcher.sv
// Self-checking bench for dmux8_dispatcher: table-driven beats, a delivery
// scoreboard, and hand-written backpressure / wrap / reset sequences.
module tb_dmux8_dispatcher;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_fixed;
   logic [2:0]  in_dest;
   logic [7:0]  out_valid;
   logic [7:0]  out_ready;
   logic [15:0] out_data;
   logic [2:0]  sel;
   logic [2:0]  rr_ptr;

   always #5 clk = ~clk;

   dmux8_dispatcher #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_fixed  (in_fixed),
      .in_dest   (in_dest),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .sel       (sel),
      .rr_ptr    (rr_ptr)
   );

   typedef struct {
      logic        fixed;
      logic [2:0]  dest;
      logic [15:0] data;
      logic [2:0]  exp_ch;
   } vec_t;

   typedef struct {
      logic [2:0]  ch;
      logic [15:0] data;
   } exp_t;

   vec_t  vecs[14];
   exp_t  sb[$];
   exp_t  pend;
   exp_t  mon_e;
   int    n_chk  = 0;
   int    n_fail = 0;
   time   t0, t1;

   function automatic logic [7:0] tb_onehot(input logic [2:0] ch);
      tb_onehot = 8'h01 << ch;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat; returns 1 time unit after the accepting edge.
   task automatic send(input logic f, input logic [2:0] d, input logic [15:0] data,
                       input logic [2:0] ec);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_fixed = f;
      in_dest  = d;
      in_data  = data;
      pend     = '{ch: ec, data: data};
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: data %0h not accepted within 50 cycles", data);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_fixed = 1'b0;
      in_dest  = '0;
      in_data  = '0;
   endtask

   // Scoreboard monitor on the falling edge, where handshakes are settled.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("out_valid_onehot0", 32'($onehot0(out_valid)), 32'd1);
         if (|(out_valid & out_ready)) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_delivery: out_valid %0h data %0h, expected none",
                        out_valid, out_data);
            end else begin
               mon_e = sb.pop_front();
               chk("deliver_ch", 32'(out_valid), 32'(tb_onehot(mon_e.ch)));
               chk("deliver_data", 32'(out_data), 32'(mon_e.data));
            end
         end
         if (in_valid && in_ready) sb.push_back(pend);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 10; i++) vecs[i] = '{1'b0, 3'd0, 16'(i + 1), 3'(i % 8)};
      vecs[10] = '{1'b1, 3'd6, 16'hBEEF, 3'd6};
      vecs[11] = '{1'b0, 3'd0, 16'h00C2, 3'd2};  // fixed beat ahead: pre-update pointer
      vecs[12] = '{1'b1, 3'd2, 16'h00D2, 3'd2};
      vecs[13] = '{1'b0, 3'd0, 16'h00C3, 3'd3};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_fixed  = 1'b0;
      in_dest   = '0;
      in_data   = '0;
      out_ready = '0;
      #22 rst_n = 1'b1;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_rr_ptr", 32'(rr_ptr), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h1);
      tick();

      // Strict rotation, one beat per cycle.
      out_ready = 8'hFF;
      t0 = $time;
      for (int i = 0; i < 10; i++) send(vecs[i].fixed, vecs[i].dest, vecs[i].data, vecs[i].exp_ch);
      t1 = $time;
      chk("rotation_cycles", 32'((t1 - t0) / 10), 32'd10);
      tick();
      tick();
      chk("rotation_rr_ptr", 32'(rr_ptr), 32'd2);
      chk("rotation_drained", 32'(sb.size()), 32'd0);

      // Fixed destination held, pointer untouched.
      out_ready = 8'h00;
      send(1'b1, 3'd6, 16'hBEEF, 3'd6);
      chk("fixed_out_valid", 32'(out_valid), 32'h40);
      chk("fixed_out_data", 32'(out_data), 32'hBEEF);
      chk("fixed_in_ready", 32'(in_ready), 32'h0);
      out_ready = 8'hFF;
      tick();
      chk("fixed_done_valid", 32'(out_valid), 32'h0);
      chk("fixed_done_sel", 32'(sel), 32'h0);
      chk("fixed_rr_ptr", 32'(rr_ptr), 32'd2);

      // Mixed fixed/round-robin beats back-to-back.
      for (int i = 10; i < 14; i++) send(vecs[i].fixed, vecs[i].dest, vecs[i].data, vecs[i].exp_ch);
      tick();
      tick();
      chk("mixed_rr_ptr", 32'(rr_ptr), 32'd4);

      // Backpressure on channel 3 with a new beat waiting.
      out_ready = 8'hF7;
      send(1'b1, 3'd3, 16'h3333, 3'd3);
      in_valid = 1'b1;
      in_fixed = 1'b0;
      in_data  = 16'h4444;
      pend     = '{ch: 3'd4, data: 16'h4444};
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'h0);
         chk("bp_sel", 32'(sel), 32'd3);
         chk("bp_out_data", 32'(out_data), 32'h3333);
         chk("bp_out_valid", 32'(out_valid), 32'h08);
      end
      @(posedge clk);
      #1;
      out_ready = 8'hFF;
      @(negedge clk);
      chk("bp_release_in_ready", 32'(in_ready), 32'h1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = '0;
      chk("bp_new_sel", 32'(sel), 32'd4);
      chk("bp_new_data", 32'(out_data), 32'h4444);
      tick();
      chk("bp_rr_ptr", 32'(rr_ptr), 32'd5);

      // Wrap from 7 to 0.
      send(1'b0, 3'd0, 16'h0505, 3'd5);
      send(1'b0, 3'd0, 16'h0606, 3'd6);
      send(1'b0, 3'd0, 16'h0707, 3'd7);
      tick();
      tick();
      chk("wrap_rr_ptr", 32'(rr_ptr), 32'd0);
      send(1'b0, 3'd0, 16'h0808, 3'd0);
      tick();
      chk("pre_reset_rr_ptr", 32'(rr_ptr), 32'd1);

      // Reset while holding a beat at channel 5.
      out_ready = 8'h00;
      send(1'b1, 3'd5, 16'h5555, 3'd5);
      chk("pre_reset_sel", 32'(sel), 32'd5);
      rst_n = 1'b0;
      #2;
      chk("reset_full_out_valid", 32'(out_valid), 32'h0);
      chk("reset_full_sel", 32'(sel), 32'h0);
      chk("reset_full_rr_ptr", 32'(rr_ptr), 32'h0);
      chk("reset_full_out_data", 32'(out_data), 32'h0);
      sb.delete();
      out_ready = 8'hFF;
      @(negedge clk);
      #2 rst_n = 1'b1;
      chk("reset_full_in_ready", 32'(in_ready), 32'h1);
      tick();
      tick();
      tick();
      chk("reset_no_old_beat", 32'(out_valid), 32'h0);

`ifdef DMUX8_SKIP_BUSY_EN
      // Skip busy channels from pointer 6.
      for (int i = 0; i < 6; i++) send(1'b0, 3'd0, 16'(16'h0100 + i), 3'(i));
      tick();
      chk("skip_setup_rr_ptr", 32'(rr_ptr), 32'd6);
      out_ready = 8'b0000_0101;
      send(1'b0, 3'd0, 16'h0A0A, 3'd0);
      chk("skip_sel", 32'(sel), 32'd0);
      tick();
      chk("skip_rr_ptr", 32'(rr_ptr), 32'd1);
      out_ready = 8'hFF;
      for (int i = 1; i < 6; i++) send(1'b0, 3'd0, 16'(16'h0200 + i), 3'(i));
      tick();
      out_ready = 8'h00;
      send(1'b0, 3'd0, 16'h0B0B, 3'd6);
      tick();
      chk("skip_none_sel", 32'(sel), 32'd6);
      chk("skip_none_valid", 32'(out_valid), 32'h40);
      out_ready = 8'hFF;
      tick();
      chk("skip_none_rr_ptr", 32'(rr_ptr), 32'd7);
`endif

      tick();
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
